// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss handler: requests a line, writes it into the victim way, forwards the critical word.
// Latency: miss accepted in IDLE -> mem_request next cycle; data writes/critical word combinational with mem_rvalid.
// Backpressure: busy stalls upstream for the whole fill; mem_request holds until mem_ack; rvalid gaps hold the fill.
module icache_fill_ctrl #(
    parameter int WAYS        = 2,
    parameter int LINE_W      = 4,
    parameter int LINE_ADDR_W = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lookup_valid,
    input  logic [31:0]                   lookup_addr,
    input  logic                          tag_hit,
    output logic                          busy,
    output logic                          mem_request,
    output logic [29:0]                   mem_addr,
    input  logic                          mem_ack,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata,
    output logic                          data_we,
    output logic [WAYS-1:0]               data_way,
    output logic [LINE_ADDR_W+$clog2(LINE_W)-1:0] data_addr,
    output logic [31:0]                   data_wdata,
    output logic                          update,
    output logic [WAYS-1:0]               update_way,
    output logic                          miss_data_valid,
    output logic [31:0]                   miss_data
);
    localparam int SUB_W  = $clog2(LINE_W);
    localparam int BASE_W = 30 - SUB_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t            state, state_nxt;
    logic [SUB_W-1:0]  cnt, cnt_nxt;
    logic [SUB_W-1:0]  offset;
    logic [BASE_W-1:0] line_base;
    logic [WAYS-1:0]   victim;
    logic              miss_take;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, lookup_addr[1:0]};

    assign miss_take = (state == IDLE) && lookup_valid && !tag_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            victim <= WAYS'(1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Rotate left; for WAYS=1 both terms are the same bit, so the pointer stays on way 0.
            if (update)
                victim <= (victim << 1) | (victim >> (WAYS - 1));
        end
    end

    // Miss context is only captured in IDLE, so it stays frozen for the whole fill.
    always_ff @(posedge clk) begin
        if (rst && miss_take) begin
            line_base <= lookup_addr[31:SUB_W+2];
            offset    <= lookup_addr[SUB_W+1:2];
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        mem_request     = 1'b0;
        data_we         = 1'b0;
        update          = 1'b0;
        miss_data_valid = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (miss_take)
                        state_nxt = REQ;
                end
                REQ: begin
                    mem_request = 1'b1;
                    if (mem_ack) begin
                        state_nxt = FILL;
                        cnt_nxt   = '0;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        data_we = 1'b1;
                        cnt_nxt = cnt + SUB_W'(1);
                        if (cnt == offset)
                            miss_data_valid = 1'b1;
                        if (cnt == SUB_W'(LINE_W - 1)) begin
                            update    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign mem_addr   = {line_base, {SUB_W{1'b0}}};
    assign data_way   = victim;
    assign update_way = victim;
    assign data_addr  = {line_base[LINE_ADDR_W-1:0], cnt};
    assign data_wdata = mem_rdata;
    assign miss_data  = mem_rdata;
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed fills with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the fill sequence.
module tb_icache_fill_ctrl;
    localparam int WAYS        = 4;
    localparam int LINE_W      = 4;
    localparam int LINE_ADDR_W = 6;
    localparam int SUB_W       = $clog2(LINE_W);

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic                          lookup_valid = 1'b0;
    logic [31:0]                   lookup_addr = '0;
    logic                          tag_hit = 1'b0;
    logic                          busy;
    logic                          mem_request;
    logic [29:0]                   mem_addr;
    logic                          mem_ack = 1'b0;
    logic                          mem_rvalid = 1'b0;
    logic [31:0]                   mem_rdata = '0;
    logic                          data_we;
    logic [WAYS-1:0]               data_way;
    logic [LINE_ADDR_W+SUB_W-1:0]  data_addr;
    logic [31:0]                   data_wdata;
    logic                          update;
    logic [WAYS-1:0]               update_way;
    logic                          miss_data_valid;
    logic [31:0]                   miss_data;

    int errors = 0;
    int checks = 0;

    icache_fill_ctrl #(.WAYS(WAYS), .LINE_W(LINE_W), .LINE_ADDR_W(LINE_ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .tag_hit(tag_hit),
        .busy(busy), .mem_request(mem_request), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .data_we(data_we), .data_way(data_way), .data_addr(data_addr), .data_wdata(data_wdata),
        .update(update), .update_way(update_way),
        .miss_data_valid(miss_data_valid), .miss_data(miss_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: a pending miss, whether it was acked, words received, victim index.
    bit          armed = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_acked = 1'b0;
    int          m_words = 0;
    int          m_vic = 0;
    logic [31:0] m_addr = '0;

    always @(negedge clk) begin
        bit          fill_rv;
        int          off;
        logic [31:0] e_maddr;
        logic [31:0] e_daddr;
        off     = int'((m_addr >> 2) % LINE_W);
        e_maddr = (m_addr >> 2) & ~32'(LINE_W - 1);
        e_daddr = ((m_addr >> (2 + SUB_W)) % (1 << LINE_ADDR_W)) * LINE_W + m_words;
        fill_rv = rst && m_pend && m_acked && mem_rvalid;
        if (armed) begin
            if (rst) chk("model_busy", 32'(busy), 32'(m_pend));
            chk("model_mem_request", 32'(mem_request), 32'(rst && m_pend && !m_acked));
            if (rst && m_pend && !m_acked) chk("model_mem_addr", 32'(mem_addr), e_maddr);
            chk("model_data_we", 32'(data_we), 32'(fill_rv));
            chk("model_update", 32'(update), 32'(fill_rv && m_words == LINE_W - 1));
            chk("model_miss_data_valid", 32'(miss_data_valid), 32'(fill_rv && m_words == off));
            if (fill_rv) begin
                chk("model_data_addr", 32'(data_addr), e_daddr);
                chk("model_data_way", 32'(data_way), 32'(1) << m_vic);
                chk("model_data_wdata", data_wdata, mem_rdata);
                if (m_words == off) chk("model_miss_data", miss_data, mem_rdata);
                if (m_words == LINE_W - 1) chk("model_update_way", 32'(update_way), 32'(1) << m_vic);
            end
        end
        if (!rst) begin
            armed   = 1'b1;
            m_pend  = 1'b0;
            m_acked = 1'b0;
            m_words = 0;
            m_vic   = 0;
        end else if (!m_pend) begin
            if (lookup_valid && !tag_hit) begin
                m_pend  = 1'b1;
                m_acked = 1'b0;
                m_words = 0;
                m_addr  = lookup_addr;
            end
        end else if (!m_acked) begin
            if (mem_ack) m_acked = 1'b1;
        end else if (mem_rvalid) begin
            m_words++;
            if (m_words == LINE_W) begin
                m_pend = 1'b0;
                m_vic  = (m_vic + 1) % WAYS;
            end
        end
    end

    task automatic do_fill(input logic [31:0] addr, input int ack_dly, input int gap,
                           input logic [WAYS-1:0] exp_way, input logic [29:0] exp_maddr,
                           input bit miss_during);
        int off;
        off = int'((addr >> 2) % LINE_W);
        lookup_valid = 1'b1;
        tag_hit      = 1'b0;
        lookup_addr  = addr;
        step();
        lookup_valid = miss_during;
        for (int d = 0; d < ack_dly; d++) begin
            #1 chk("req_wait_mem_request", 32'(mem_request), 32'd1);
            step();
        end
        mem_ack = 1'b1;
        #1 chk("req_mem_addr", 32'(mem_addr), 32'(exp_maddr));
        chk("req_busy", 32'(busy), 32'd1);
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < LINE_W; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rvalid = 1'b0;
                    #1 chk("gap_data_we", 32'(data_we), 32'd0);
                    step();
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA000_0000 + 32'(i);
            #1 chk("fill_word_offset", 32'(data_addr[SUB_W-1:0]), 32'(i));
            chk("fill_critical", 32'(miss_data_valid), 32'(i == off));
            if (i == off) chk("fill_critical_data", miss_data, 32'hA000_0000 + 32'(i));
            if (i == LINE_W - 1) begin
                chk("fill_update", 32'(update), 32'd1);
                chk("fill_update_way", 32'(update_way), 32'(exp_way));
            end
            step();
        end
        mem_rvalid   = 1'b0;
        lookup_valid = 1'b0;
        #1 chk("fill_done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1 chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_request", 32'(mem_request), 32'd0);
        chk("reset_update", 32'(update), 32'd0);
        step();

        do_fill(32'h0000_1008, 2, 0, 4'b0001, 30'h400, 1'b0);
        step();
        do_fill(32'h0000_2000, 0, 0, 4'b0010, 30'h800, 1'b1);
        do_fill(32'h0000_30C4, 1, 1, 4'b0100, 30'hC30, 1'b0);
        do_fill(32'h0000_0010, 0, 0, 4'b1000, 30'h004, 1'b0);
        do_fill(32'h0000_0000, 0, 3, 4'b0001, 30'h000, 1'b0);

        lookup_valid = 1'b1;
        tag_hit      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("hit_busy", 32'(busy), 32'd0);
            chk("hit_mem_request", 32'(mem_request), 32'd0);
            chk("hit_data_we", 32'(data_we), 32'd0);
        end
        lookup_valid = 1'b0;
        tag_hit      = 1'b0;

        // Partial fill aborted by reset after two words.
        step();
        lookup_valid = 1'b1;
        lookup_addr  = 32'h0000_5004;
        step();
        lookup_valid = 1'b0;
        mem_ack      = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB000_0000 + 32'(i);
            step();
        end
        rst = 1'b0;
        step();
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        #1 chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_update", 32'(update), 32'd0);
        step();
        do_fill(32'h0000_1000, 0, 0, 4'b0001, 30'h400, 1'b0);

        for (int c = 0; c < 4000; c++) begin
            step();
            rst = ($urandom_range(0, 249) != 0);
            if (!busy) begin
                lookup_addr = $urandom;
                tag_hit     = $urandom_range(0, 1) == 1;
            end
            lookup_valid = $urandom_range(0, 2) != 0;
            mem_ack      = $urandom_range(0, 2) == 0;
            mem_rvalid   = $urandom_range(0, 1) == 1;
            mem_rdata    = $urandom;
        end
        rst = 1'b1;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
